// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, both on
// operand magnitudes with a sign fixup in a final cycle. The whole op takes DATA_W+1 cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op       MDU op valid in EX; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b    dividend/multiplicand, divisor/multiplier
//   hi_we, lo_we    MTHI / MTLO write enables, wdata is their data
//   flush           cancel any op in EX; HI/LO are left untouched
//   ready           0 = EX must stall
//   hi_o, lo_o      registered HI / LO
module mdu_iterative #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              ready,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // opnd_q: multiplicand (MUL) or divisor (DIV).
  // quo_q: multiplier / product low half (MUL) or dividend / quotient (DIV).
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                in_signed, a_neg, b_neg, b_zero;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & src_a[DATA_W-1];
    b_neg     = in_signed & src_b[DATA_W-1];
    b_zero    = (src_b == '0);
    a_abs     = a_neg ? -src_a : src_a;
    b_abs     = b_neg ? -src_b : src_b;

    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {rem_q, quo_q[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below opnd_q, so DATA_W bits suffice.
    div_diff  = div_shift[DATA_W-1:0] - opnd_q;

    prod      = {rem_q, quo_q};
    prod_fix  = neg_res_q ? -prod : prod;
    quo_fix   = neg_res_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
  end

  assign ready = flush | ~(((state_q == StIdle) & start) | (state_q == StCalc));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (hi_we & ~flush) hi_d = wdata;
    if (lo_we & ~flush) lo_d = wdata;

    unique case (state_q)
      StIdle: begin
        if (start & ~flush) begin
          is_div_d  = op[1];
          // Divide-by-zero keeps the all-ones quotient unsigned-looking.
          neg_res_d = (a_neg ^ b_neg) & ~(op[1] & b_zero);
          neg_rem_d = a_neg;
          cnt_d     = '0;
          rem_d     = '0;
          opnd_d    = op[1] ? b_abs : a_abs;
          quo_d     = op[1] ? a_abs : b_abs;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          rem_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], div_ge};
        end else begin
          rem_d = mul_sum[DATA_W:1];
          quo_d = {mul_sum[0], quo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = StFix;
      end
      StFix: begin
        // Result write overrides any concurrent MTHI/MTLO.
        if (~flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      opnd_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vectors, corner sequences
// (flush, back-to-back, MTLO, async reset) and random ops against an arithmetic model.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        hi_we, lo_we, flush;
  logic        ready;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;

  mdu_iterative #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .ready (ready),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the architectural special cases.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        ps = longint'(sa) * longint'(sb);
        {h, l} = ps;
      end
      2'b01: begin
        pu = {32'h0, a} * {32'h0, b};
        {h, l} = pu;
      end
      2'b10: begin
        if (b == 32'h0) begin
          l = 32'hffff_ffff; h = a;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          l = 32'h8000_0000; h = 32'h0;
        end else begin
          l = sa / sb; h = sa % sb;
        end
      end
      default: begin
        if (b == 32'h0) begin
          l = 32'hffff_ffff; h = a;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Presents an op at a negedge, holds start while stalled, returns after the
  // commit edge. start is left high; the caller drops it or issues the next op.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lows);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    lows = 0;
    while (1) begin
      #1;
      if (ready) break;
      lows++;
      if (lows > 100) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          lat;
    logic [31:0] eh, el;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'hffff_fffb, 32'h3,         32'hffff_ffff, 32'hffff_fff1};
    vecs[1] = '{2'b01, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001};
    vecs[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[3] = '{2'b10, 32'hffff_fff9, 32'd2,         32'hffff_ffff, 32'hffff_fffd};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hffff_ffff, 32'h0,         32'h8000_0000};
    vecs[5] = '{2'b11, 32'd9,         32'd0,         32'd9,         32'hffff_ffff};

    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    #12;
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_ready", {31'b0, ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd33);
      check($sformatf("vec%0d_hi", i), hi_o, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo_o, vecs[i].lo);
      go_idle();
    end

    // Flush at CALC cycle 10 of a MULT; HI/LO keep the last vector's result
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
    repeat (11) @(negedge clk);
    #1;
    check("flush_pre_ready", {31'b0, ready}, 32'h0);
    flush = 1'b1;
    #1;
    check("flush_ready", {31'b0, ready}, 32'h1);
    @(posedge clk);
    #1;
    check("flush_hi", hi_o, vecs[5].hi);
    check("flush_lo", lo_o, vecs[5].lo);
    flush = 1'b0;
    run_op(2'b11, 32'd100, 32'd7, lat);
    check("post_flush_latency", lat, 32'd33);
    check("post_flush_hi", hi_o, 32'd2);
    check("post_flush_lo", lo_o, 32'd14);
    go_idle();

    // MTLO then back-to-back MULTs
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo_o, 32'h1234);
    run_op(2'b00, 32'd2, 32'd3, lat);
    check("b2b1_lo", lo_o, 32'd6);
    check("b2b1_hi", hi_o, 32'd0);
    run_op(2'b00, 32'd4, 32'd5, lat);
    check("b2b2_latency", lat, 32'd33);
    check("b2b2_lo", lo_o, 32'd20);
    go_idle();

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hffff_ffff; end
        2: begin ra = $urandom_range(0, 50) - 25; rb = $urandom_range(0, 10) - 5; end
        default: ;
      endcase
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, lat);
      check($sformatf("rnd%0d_latency op=%0d", i, ro), lat, 32'd33);
      check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb), hi_o, eh);
      check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb), lo_o, el);
      go_idle();
    end

    // MTHI/MTLO, then async reset in the middle of CALC
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hdead_beef;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_hi", hi_o, 32'hdead_beef);
    start = 1'b1; op = 2'b01; src_a = 32'd123; src_b = 32'd456;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    check("arst_hi", hi_o, 32'h0);
    check("arst_lo", lo_o, 32'h0);
    check("arst_ready", {31'b0, ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_late_hi", hi_o, 32'h0);
    check("arst_late_lo", lo_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
